// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage of the 5-stage RISC-V pipeline.
// Performs the data-memory handshake for loads and stores. It formats store
// strobes/data and load data by size and sign, applies the writeback select,
// and holds the MEM/WB pipeline register. stall_o freezes the upstream stages
// while an access is outstanding.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   alu_result_i            effective address or ALU result
//   store_data_i            rs2 data for stores
//   pc_plus_4_i             link value for JAL/JALR
//   mem_read_i/mem_write_i  load / store request from EX/MEM
//   mem_to_reg_i            writeback select: 00 ALU, 01 load, 10 pc+4, 11 ALU
//   reg_write_i, rd_i       destination write enable / register
//   funct3_i                access size and sign
//   dmem_*                  data-memory handshake (driven only in ACCESS)
//   stall_o                 freeze upstream pipeline registers
//   wb_data_o/wb_rd_o/wb_reg_write_o  MEM/WB register outputs
//   misaligned_o, bus_err_o one-cycle pulses for dropped / timed-out accesses
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] pc_plus_4_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_to_reg_i,
  input  logic        reg_write_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        stall_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_write_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state, state_next;
  logic [7:0]  count, count_next;
  logic [1:0]  byte_off;
  logic        aligned, is_mem, access_valid;
  logic [3:0]  store_wstrb;
  logic [31:0] store_wdata, lane, load_data, wb_sel;
  logic        stall, wb_we_next, mis_next, berr_next;

  assign byte_off     = alu_result_i[1:0];
  assign is_mem       = mem_read_i | mem_write_i;
  assign access_valid = is_mem & aligned;

  // Size comes from funct3[1:0]; encodings 11 are handled as word accesses.
  always_comb begin
    aligned = (byte_off == 2'b00);
    case (funct3_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_result_i[0];
      default: aligned = (byte_off == 2'b00);
    endcase
  end

  always_comb begin
    store_wstrb = 4'b1111;
    store_wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        store_wstrb = 4'b0001 << byte_off;
        store_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        store_wstrb = 4'b0011 << byte_off;
        store_wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dmem_rdata_i >> {byte_off, 3'b000};

  always_comb begin
    case (funct3_i)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'b0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'b0, lane[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    case (mem_to_reg_i)
      2'b01:   wb_sel = load_data;
      2'b10:   wb_sel = pc_plus_4_i;
      default: wb_sel = alu_result_i;
    endcase
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    stall        = 1'b0;
    // A store never writes rd, even when mem_read_i is also set.
    wb_we_next   = reg_write_i & ~mem_write_i;
    mis_next     = 1'b0;
    berr_next    = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'b0;
    dmem_wdata_o = 32'b0;
    dmem_wstrb_o = 4'b0;
    case (state)
      StIdle: begin
        if (access_valid) begin
          stall      = 1'b1;
          state_next = StAccess;
          count_next = 8'd0;
        end else if (is_mem) begin
          mis_next   = 1'b1;
          wb_we_next = 1'b0;
        end
      end
      StAccess: begin
        dmem_req_o  = 1'b1;
        dmem_we_o   = mem_write_i;
        dmem_addr_o = {alu_result_i[31:2], 2'b00};
        if (mem_write_i) begin
          dmem_wdata_o = store_wdata;
          dmem_wstrb_o = store_wstrb;
        end
        if (dmem_ready_i) begin
          state_next = StIdle;
        end else if (count == 8'(TIMEOUT_CYCLES - 1)) begin
          // Abort: let the pipeline advance but retire nothing.
          state_next = StIdle;
          berr_next  = 1'b1;
          wb_we_next = 1'b0;
        end else begin
          stall      = 1'b1;
          count_next = count + 8'd1;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  // Gate with reset so the upstream freeze drops the moment reset asserts.
  assign stall_o = stall & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= StIdle;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data_o      <= 32'b0;
      wb_rd_o        <= 5'b0;
      wb_reg_write_o <= 1'b0;
      misaligned_o   <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      misaligned_o <= mis_next;
      bus_err_o    <= berr_next;
      if (stall) begin
        wb_reg_write_o <= 1'b0;
      end else begin
        wb_reg_write_o <= wb_we_next;
        // A timed-out access leaves data/rd as they were.
        if (!berr_next) begin
          wb_data_o <= wb_sel;
          wb_rd_o   <= rd_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: a driver issues directed instructions and acts as
// data memory; a monitor pops expected MEM/WB results from a scoreboard queue
// on every cycle where the MEM/WB register captured (stall_o low at the edge).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_i, store_data_i, pc_plus_4_i;
  logic        mem_read_i, mem_write_i, reg_write_i;
  logic [1:0]  mem_to_reg_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o, dmem_ready_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_wstrb_o;
  logic        stall_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o, misaligned_o, bus_err_o;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_result_i   (alu_result_i),
    .store_data_i   (store_data_i),
    .pc_plus_4_i    (pc_plus_4_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .mem_to_reg_i   (mem_to_reg_i),
    .reg_write_i    (reg_write_i),
    .rd_i           (rd_i),
    .funct3_i       (funct3_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_wstrb_o   (dmem_wstrb_o),
    .dmem_rdata_i   (dmem_rdata_i),
    .dmem_ready_i   (dmem_ready_i),
    .stall_o        (stall_o),
    .wb_data_o      (wb_data_o),
    .wb_rd_o        (wb_rd_o),
    .wb_reg_write_o (wb_reg_write_o),
    .misaligned_o   (misaligned_o),
    .bus_err_o      (bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        berr;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  logic mon_en = 1'b0;
  logic cap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares on the negedge following a capturing posedge.
  always @(negedge clk) begin
    if (cap) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: capture with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_reg_write", 32'(wb_reg_write_o), 32'(mon_e.we));
        chk("misaligned", 32'(misaligned_o), 32'(mon_e.mis));
        chk("bus_err", 32'(bus_err_o), 32'(mon_e.berr));
        if (mon_e.chk_data) begin
          chk("wb_data", wb_data_o, mon_e.data);
          chk("wb_rd", 32'(wb_rd_o), 32'(mon_e.rd));
        end
      end
    end
    #4;
    cap = mon_en && reset && !stall_o;
  end

  // Issue one instruction at a negedge; returns at the negedge after it retires.
  task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [31:0] pc, input logic rd_en, input logic wr_en,
                       input logic [1:0] m2r, input logic rw, input logic [4:0] rd,
                       input logic [2:0] f3, input int ready_on, input logic [31:0] rdata,
                       input int e_cyc, input logic [31:0] e_addr, input logic e_we,
                       input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                       input logic [31:0] e_wb, input logic e_rw, input logic e_mis,
                       input logic e_berr, input logic e_chk);
    exp_t e;
    int   acc;
    int   stalls;
    bit   done;
    e.data = e_wb; e.rd = rd; e.we = e_rw; e.mis = e_mis; e.berr = e_berr; e.chk_data = e_chk;
    sb.push_back(e);
    alu_result_i = alu; store_data_i = sdata; pc_plus_4_i = pc;
    mem_read_i = rd_en; mem_write_i = wr_en; mem_to_reg_i = m2r;
    reg_write_i = rw; rd_i = rd; funct3_i = f3;
    dmem_ready_i = 1'b0; dmem_rdata_i = 32'b0;
    acc = 0; stalls = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (dmem_req_o) begin
        acc++;
        if (acc == 1) begin
          chk({name, "_addr"}, dmem_addr_o, e_addr);
          chk({name, "_we"}, 32'(dmem_we_o), 32'(e_we));
          if (e_we) begin
            chk({name, "_wstrb"}, 32'(dmem_wstrb_o), 32'(e_wstrb));
            chk({name, "_wdata"}, dmem_wdata_o, e_wdata);
          end
        end
        if (acc == ready_on) begin
          dmem_ready_i = 1'b1;
          dmem_rdata_i = rdata;
          #1;
        end
      end
      if (stall_o) begin
        stalls++;
        if (cyc > 0) chk({name, "_wb_we_stall"}, 32'(wb_reg_write_o), 32'd0);
      end else begin
        done = 1'b1;
      end
      @(negedge clk);
      dmem_ready_i = 1'b0;
      dmem_rdata_i = 32'b0;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_complete: stall_o still high after 300 cycles", name);
    end
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(e_cyc));
    chk({name, "_req_cycles"}, 32'(acc), 32'(e_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_result_i = 32'h100; store_data_i = 32'b0; pc_plus_4_i = 32'b0;
    mem_read_i = 1'b1; mem_write_i = 1'b0; mem_to_reg_i = 2'b01;
    reg_write_i = 1'b1; rd_i = 5'd1; funct3_i = 3'b010;
    dmem_ready_i = 1'b0; dmem_rdata_i = 32'b0;
    #2 reset = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    // A valid load is presented during reset: no stall, no request.
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd_o), 32'd0);
    chk("rst_wb_we", 32'(wb_reg_write_o), 32'd0);
    chk("rst_mis", 32'(misaligned_o), 32'd0);
    chk("rst_berr", 32'(bus_err_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    //    name    alu           sdata         pc            rd wr m2r   rw rd     f3      rdy rdata         cyc addr          we strb     wdata         wb            rw mis be chk
    issue("alu",  32'h1234,     32'h0,        32'h0,        0, 0, 2'b00, 1, 5'd5,  3'b000, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h1234,     1, 0, 0, 1);
    issue("lb",   32'h103,      32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd7,  3'b000, 3, 32'h80FF0000, 3, 32'h100,      0, 4'b0000, 32'h0,        32'hFFFFFF80, 1, 0, 0, 1);
    issue("sh",   32'h22,       32'hAAAABEEF, 32'h0,        0, 1, 2'b00, 1, 5'd9,  3'b001, 1, 32'h0,        1, 32'h20,       1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 0, 0);
    issue("lw_mis", 32'h41,     32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd3,  3'b010, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 1, 0, 0);
    issue("jal",  32'hDEAD,     32'h0,        32'h00400008, 0, 0, 2'b10, 1, 5'd1,  3'b000, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h00400008, 1, 0, 0, 1);
    issue("lbu",  32'h102,      32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd10, 3'b100, 2, 32'h1280FF34, 2, 32'h100,      0, 4'b0000, 32'h0,        32'h00000080, 1, 0, 0, 1);
    issue("lh",   32'h102,      32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd11, 3'b001, 1, 32'h80015555, 1, 32'h100,      0, 4'b0000, 32'h0,        32'hFFFF8001, 1, 0, 0, 1);
    issue("lhu",  32'h100,      32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd12, 3'b101, 1, 32'h12349ABC, 1, 32'h100,      0, 4'b0000, 32'h0,        32'h00009ABC, 1, 0, 0, 1);
    issue("lw",   32'h200,      32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd13, 3'b010, 1, 32'hCAFEF00D, 1, 32'h200,      0, 4'b0000, 32'h0,        32'hCAFEF00D, 1, 0, 0, 1);
    issue("sb",   32'h13,       32'h00000055, 32'h0,        0, 1, 2'b00, 1, 5'd14, 3'b000, 1, 32'h0,        1, 32'h10,       1, 4'b1000, 32'h55555555, 32'h0,        0, 0, 0, 0);
    issue("sw",   32'h44,       32'h01234567, 32'h0,        0, 1, 2'b00, 1, 5'd15, 3'b010, 1, 32'h0,        1, 32'h44,       1, 4'b1111, 32'h01234567, 32'h0,        0, 0, 0, 0);
    issue("lh_mis", 32'h101,    32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd16, 3'b001, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 1, 0, 0);
    issue("rw_both", 32'h48,    32'h0BADF00D, 32'h0,        1, 1, 2'b01, 1, 5'd17, 3'b010, 1, 32'h0,        1, 32'h48,       1, 4'b1111, 32'h0BADF00D, 32'h0,        0, 0, 0, 0);
    issue("lw_tmo", 32'h300,    32'h0,        32'h0,        1, 0, 2'b01, 1, 5'd18, 3'b010, 0, 32'h0,        4, 32'h300,      0, 4'b0000, 32'h0,        32'h0,        0, 0, 1, 0);
    issue("alu2", 32'h77,       32'h0,        32'h0,        0, 0, 2'b00, 1, 5'd2,  3'b000, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h77,       1, 0, 0, 1);
    issue("rd0",  32'h99,       32'h0,        32'h0,        0, 0, 2'b00, 1, 5'd0,  3'b000, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h99,       1, 0, 0, 1);
    issue("alu11", 32'hABCD,    32'h0,        32'h0,        0, 0, 2'b11, 1, 5'd4,  3'b000, 0, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'hABCD,     1, 0, 0, 1);
    mon_en = 1'b0;

    // Reset in the middle of an outstanding load.
    alu_result_i = 32'h80; mem_read_i = 1'b1; mem_write_i = 1'b0; mem_to_reg_i = 2'b01;
    reg_write_i = 1'b1; rd_i = 5'd6; funct3_i = 3'b010;
    #1 chk("mid_idle_stall", 32'(stall_o), 32'd1);
    @(negedge clk); #1;
    chk("mid_access_req", 32'(dmem_req_o), 32'd1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_addr", dmem_addr_o, 32'd0);
    chk("mid_rst_wb_data", wb_data_o, 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_rd_o), 32'd0);
    chk("mid_rst_wb_we", 32'(wb_reg_write_o), 32'd0);
    chk("mid_rst_berr", 32'(bus_err_o), 32'd0);
    @(negedge clk);
    mem_read_i = 1'b0; reg_write_i = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_req", 32'(dmem_req_o), 32'd0);
    chk("post_rst_stall", 32'(stall_o), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
